// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: AND/OR/ADD/SUB evaluated LSB-first, one bit per clock.
// Define SERIAL_ALU_OVERFLOW_EN to add the rsp_ovf signed-overflow output.
module serial_alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             busy
`ifdef SERIAL_ALU_OVERFLOW_EN
  ,
  output logic             rsp_ovf
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_SUB = 2'b11;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sr;
  logic [1:0]       r_op;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_zero;
`ifdef SERIAL_ALU_OVERFLOW_EN
  logic             r_ovf;
`endif

  logic             w_accept;
  logic             w_last;
  logic             w_a;
  logic             w_b;
  logic             w_bit;
  logic             w_carry;
  logic [WIDTH-1:0] w_sr_next;

  assign w_accept  = req_valid && (r_state == S_IDLE);
  assign w_last    = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_a       = r_sa[0];
  assign w_b       = r_sb[0];
  assign w_sr_next = {w_bit, r_sr[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // One-bit slice; the carry only ripples for ADD/SUB, logic ops keep it at 0.
  always_comb begin
    w_bit   = 1'b0;
    w_carry = 1'b0;
    case (r_op)
      2'b00:   w_bit = w_a & w_b;
      2'b01:   w_bit = w_a | w_b;
      default: begin
        w_bit   = w_a ^ w_b ^ r_c;
        w_carry = (w_a & w_b) | (w_a & r_c) | (w_b & r_c);
      end
    endcase
  end

  // NOTE: these are plain flops, not a memory, so a synchronous clear of every one is cheap and safe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_op     <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
`ifdef SERIAL_ALU_OVERFLOW_EN
      r_ovf    <= 1'b0;
`endif
    end else if (w_accept) begin
      // SUB is A + ~B + 1, so invert B and preset the carry.
      r_sa  <= req_a;
      r_sb  <= (req_op == OP_SUB) ? ~req_b : req_b;
      r_op  <= req_op;
      r_c   <= (req_op == OP_SUB);
      r_cnt <= '0;
      r_sr  <= '0;
    end else if (r_state == S_RUN) begin
      r_sa  <= r_sa >> 1;
      r_sb  <= r_sb >> 1;
      r_sr  <= w_sr_next;
      r_c   <= w_carry;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_sr_next;
        r_cout   <= w_carry;
        r_zero   <= (w_sr_next == '0);
`ifdef SERIAL_ALU_OVERFLOW_EN
        // On the MSB slice r_c is the carry in, w_carry the carry out.
        r_ovf    <= r_c ^ w_carry;
`endif
      end
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_DONE);
  assign busy       = (r_state == S_RUN);
  assign rsp_result = r_result;
  assign rsp_cout   = r_cout;
  assign rsp_zero   = r_zero;
`ifdef SERIAL_ALU_OVERFLOW_EN
  assign rsp_ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// Scoreboard bench for serial_alu_seq: directed vectors, expected responses queued at issue
// and checked by an independent monitor on each response handshake.
module tb_serial_alu_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [1:0]   req_op = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic         rsp_cout;
  logic         rsp_zero;
  logic         busy;
`ifdef SERIAL_ALU_OVERFLOW_EN
  logic         rsp_ovf;
`endif

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_cout  (rsp_cout),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
`ifdef SERIAL_ALU_OVERFLOW_EN
    ,
    .rsp_ovf   (rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake happens at the next rising edge, so pop and compare here.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_result), 64'hdead);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rsp_result", 64'(rsp_result), 64'(e.result));
        check("rsp_cout",   64'(rsp_cout),   64'(e.cout));
        check("rsp_zero",   64'(rsp_zero),   64'(e.zero));
`ifdef SERIAL_ALU_OVERFLOW_EN
        check("rsp_ovf",    64'(rsp_ovf),    64'(e.ovf));
`endif
      end
    end
  end

  // Issue one request; operand inputs are scrambled right after the accept edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                        input logic [W-1:0] er, input logic ec, input logic ez, input logic ev,
                        input int hold);
    int lat;
    exp_t e;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    rsp_ready = (hold == 0);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    e.result = er; e.cout = ec; e.zero = ez; e.ovf = ev;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a = ~a;
    req_b = ~b;
    check("busy_run", 64'(busy), 64'd1);
    check("req_ready_run", 64'(req_ready), 64'd0);
    lat = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      lat++;
      if (rsp_valid) break;
    end
    check("latency", 64'(lat), 64'(W));
    if (!rsp_valid) return;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_result", 64'(rsp_result), 64'(er));
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_drop", 64'(rsp_valid), 64'd0);
    check("back_idle", 64'(req_ready), 64'd1);
    check("result_held", 64'(rsp_result), 64'(er));
  endtask

  initial begin
    int seen;
    // Reset and idle state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_result",    64'(rsp_result), 64'd0);
    check("rst_cout",      64'(rsp_cout),  64'd0);
    check("rst_zero",      64'(rsp_zero),  64'd0);

    //      A             B             op     result        c     z     ovf   hold
    run_op(32'h0000_0005, 32'h0000_0003, 2'b10, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 2'b10, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 2'b10, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 0);
    run_op(32'h0000_0003, 32'h0000_0005, 2'b11, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0);
    run_op(32'h0000_0005, 32'h0000_0005, 2'b11, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 0);
    run_op(32'h8000_0000, 32'h0000_0001, 2'b11, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 0);
    run_op(32'hF0F0_1234, 32'h0FF0_FF00, 2'b00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 0);
    run_op(32'hF0F0_1234, 32'h0FF0_FF00, 2'b01, 32'hFFF0_FF34, 1'b0, 1'b0, 1'b0, 0);
    run_op(32'h1234_5678, 32'h1111_1111, 2'b10, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 10);
    run_op(32'h0000_0100, 32'h0000_0001, 2'b10, 32'h0000_0101, 1'b0, 1'b0, 1'b0, 0);

    // Reset while RUN at cnt=10: the in-flight result must be dropped.
    @(negedge clk);
    req_a = 32'h0000_0042; req_b = 32'h0000_0001; req_op = 2'b10; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_busy",      64'(busy),      64'd0);
    check("midrst_valid",     64'(rsp_valid), 64'd0);
    check("midrst_result",    64'(rsp_result), 64'd0);
    seen = 0;
    repeat (W + 10) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("midrst_no_rsp", 64'(seen), 64'd0);

    run_op(32'h0000_0005, 32'h0000_0003, 2'b10, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Multi-cycle bit-serial ALU sequencer for the RISC-V core.
- Accepts WIDTH-bit operands and an op code over a valid/ready request channel.
- Evaluates them LSB-first, one bit per cycle, through a 1-bit slice function with a registered carry.
- Returns the full result, carry-out and zero flag over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit-counter width.

Ports:
- clk  input  1  single rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request operands valid.
- req_ready  output  1  sequencer idle, can accept request.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- req_op  input  2  00 AND, 01 OR, 10 ADD, 11 SUB (A-B).
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_result  output  WIDTH  computed result.
- rsp_cout  output  1  final carry out; 0 for AND/OR.
- rsp_zero  output  1  rsp_result == 0.
- busy  output  1  computation in progress (state RUN).

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - state=IDLE; all internal registers cleared.
  - Outputs: req_ready=1, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_zero=0, busy=0.
  - rst overrides any in-flight RUN or DONE; the pending result is discarded and no rsp_valid pulse occurs.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch A into shift reg sa, B into sb (SUB: latch ~B), op, and carry c (1 for SUB, 0 otherwise); clear cnt and the result shift reg sr; go to RUN.
  - Operands are sampled only on the accept edge; later changes to req_a/req_b are ignored.
- RUN (busy=1, req_ready=0):
  - Each cycle: a=sa[0], b=sb[0].
  - Slice bit: AND a&b; OR a|b; ADD/SUB a^b^c.
  - New carry: ADD/SUB (a&b)|(a&c)|(b&c); AND/OR carry held at 0.
  - sr shifts right with the slice bit entering at MSB; sa and sb shift right; cnt++.
  - When cnt==WIDTH-1 at the edge: register final sr into rsp_result, final carry into rsp_cout and zero flag into rsp_zero; go to DONE.
- Latency: request accept edge to rsp_valid high = exactly WIDTH cycles (WIDTH RUN cycles, rsp_valid asserted the following cycle in DONE).
- DONE:
  - rsp_valid=1; req_ready=0; rsp_* held stable until the handshake.
  - On rsp_ready: next cycle state=IDLE and rsp_valid=0.
  - rsp_result/rsp_cout/rsp_zero keep their last values in IDLE until the next DONE.
- Back-to-back:
  - The next request can be accepted at the earliest in the cycle after the rsp handshake (IDLE cycle).
  - No overlap; throughput is one op per WIDTH+2 cycles minimum.
- rsp_ready held high in advance: DONE still lasts exactly one cycle; no combinational path from rsp_ready to req_ready.
- req_valid while busy: ignored (req_ready=0); the requester must hold.
- SUB semantics: rsp_cout=1 means no borrow (A>=B unsigned).
- All arithmetic is modulo 2^WIDTH; no sign extension.

Optional Feature:
- Macro: SERIAL_ALU_OVERFLOW_EN.
- Defined:
  - Adds output port rsp_ovf (1 bit), signed overflow for ADD/SUB.
  - rsp_ovf = carry into MSB XOR carry out of MSB, captured on the last RUN cycle.
  - 0 for AND/OR; reset value 0; held like the other rsp_* outputs.
- Undefined: port absent; no overflow logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> req_ready=1, rsp_valid=0, busy=0, rsp_result=0 and rsp_cout=0.
- ADD A=0x0000_0005, B=0x0000_0003 -> rsp_valid exactly 32 cycles after accept, rsp_result=0x0000_0008, rsp_cout=0, rsp_zero=0.
- ADD A=0xFFFF_FFFF, B=0x0000_0001 -> rsp_result=0, rsp_cout=1, rsp_zero=1; with SERIAL_ALU_OVERFLOW_EN, rsp_ovf=0. Follow with ADD 0x7FFF_FFFF+1 -> rsp_ovf=1.
- SUB A=3, B=5 -> rsp_result=0xFFFF_FFFE, rsp_cout=0. SUB A=5, B=5 -> rsp_result=0, rsp_cout=1, rsp_zero=1.
- AND/OR A=0xF0F0_1234, B=0x0FF0_FF00 -> AND 0x00F0_1200, OR 0xFFF0_FF34, rsp_cout=0.
- Backpressure and reset mid-op:
  - Hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_result stable, req_ready=0.
  - rst asserted at cnt=10 of a RUN -> next cycle IDLE, rsp_valid never pulses.
  - Change req_a during RUN -> result unaffected.
